bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 10 +
 rtl/rr_arbiter3.sv | 17 +
 rtl/bus_arbiter.sv | 101 ++++++++++
 tb/tb_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared widths, requester IDs and FSM states for the bus arbiter
package bus_arbiter_pkg;
  localparam int DEF_BUS_WIDTH = 32;
  localparam int DEF_BUS_RESP_WIDTH = 1;
  typedef enum logic [1:0] {ID_IR = 2'd0, ID_DR = 2'd1, ID_DW = 2'd2} req_id_t;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DELIVER = 2'd3} state_t;
  function automatic req_id_t onehot_to_id(input logic [2:0] g);
    return g[2] ? ID_DW : g[1] ? ID_DR : ID_IR;
  endfunction
endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: combinational three-way round-robin, priority starts after last
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] grant
);
  logic [1:0] idx;
  // scan from lowest to highest priority so the highest-priority match is written last
  always_comb begin
    grant = 3'b000;
    idx = 2'd0;
    for (int i = 3; i >= 1; i--) begin
      idx = 2'((int'(last) + i) % 3);
      if (req[idx]) grant = 3'b001 << idx;
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one single-port memory between IR, DR and DW requesters,
// one transaction outstanding, round-robin grant.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int BUS_RESP_WIDTH = DEF_BUS_RESP_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      bus_ir_addr_valid,
  output logic                      bus_ir_addr_ready,
  input  logic [BUS_WIDTH-1:0]      bus_ir_addr_bits,
  output logic                      bus_ir_data_valid,
  input  logic                      bus_ir_data_ready,
  output logic [BUS_WIDTH-1:0]      bus_ir_data_bits,
  input  logic                      bus_dr_addr_valid,
  output logic                      bus_dr_addr_ready,
  input  logic [BUS_WIDTH-1:0]      bus_dr_addr_bits,
  output logic                      bus_dr_data_valid,
  input  logic                      bus_dr_data_ready,
  output logic [BUS_WIDTH-1:0]      bus_dr_data_bits,
  input  logic                      bus_dw_req_valid,
  output logic                      bus_dw_req_ready,
  input  logic [BUS_WIDTH-1:0]      bus_dw_req_bits_addr,
  input  logic [BUS_WIDTH-1:0]      bus_dw_req_bits_data,
  input  logic [BUS_WIDTH/8-1:0]    bus_dw_req_bits_strobe,
  output logic                      bus_dw_resp_valid,
  input  logic                      bus_dw_resp_ready,
  output logic [BUS_RESP_WIDTH-1:0] bus_dw_resp_bits,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_write,
  output logic [BUS_WIDTH-1:0]      mem_req_addr,
  output logic [BUS_WIDTH-1:0]      mem_req_data,
  output logic [BUS_WIDTH/8-1:0]    mem_req_strobe,
  input  logic                      mem_resp_valid,
  output logic                      mem_resp_ready,
  input  logic [BUS_WIDTH-1:0]      mem_resp_data,
  input  logic                      mem_resp_err
);
  state_t state, state_n;
  req_id_t last_id, owner;
  logic [2:0] grant;
  logic accept, deliver_ack;
  logic [BUS_WIDTH-1:0] resp_data;
  logic resp_err;

  rr_arbiter3 u_rr (
    .req({bus_dw_req_valid, bus_dr_addr_valid, bus_ir_addr_valid}),
    .last(last_id),
    .grant(grant)
  );

  always_comb begin
    {bus_dw_req_ready, bus_dr_addr_ready, bus_ir_addr_ready} = (state == IDLE && reset) ? grant : 3'b000;
    accept = (|grant) && state == IDLE && reset;
    deliver_ack = owner == ID_IR ? bus_ir_data_ready : owner == ID_DR ? bus_dr_data_ready : bus_dw_resp_ready;
    state_n = (state == IDLE && accept) ? REQ :
              (state == REQ && mem_req_ready) ? RESP :
              (state == RESP && mem_resp_valid) ? DELIVER :
              (state == DELIVER && deliver_ack) ? IDLE : state;
  end

  assign mem_req_valid = state == REQ;
  assign mem_resp_ready = state == RESP;
  assign bus_ir_data_valid = state == DELIVER && owner == ID_IR;
  assign bus_dr_data_valid = state == DELIVER && owner == ID_DR;
  assign bus_dw_resp_valid = state == DELIVER && owner == ID_DW;
  assign bus_ir_data_bits = resp_data;
  assign bus_dr_data_bits = resp_data;
  assign bus_dw_resp_bits = BUS_RESP_WIDTH'(resp_err);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      last_id <= ID_DW;
      owner <= ID_IR;
      mem_req_write <= 1'b0;
      mem_req_addr <= '0;
      mem_req_data <= '0;
      mem_req_strobe <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        last_id <= onehot_to_id(grant);
        owner <= onehot_to_id(grant);
        mem_req_write <= grant[2];
        mem_req_addr <= grant[2] ? bus_dw_req_bits_addr : grant[1] ? bus_dr_addr_bits : bus_ir_addr_bits;
        mem_req_data <= grant[2] ? bus_dw_req_bits_data : '0;
        mem_req_strobe <= grant[2] ? bus_dw_req_bits_strobe : '0;
      end
      if (state == RESP && mem_resp_valid) begin
        resp_data <= mem_resp_data;
        resp_err <= mem_resp_err;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized transactions checked against a
// round-robin / memory reference model.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;
  localparam int W = 32;
  localparam int SW = W / 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic bus_ir_addr_valid = 0, bus_ir_addr_ready, bus_ir_data_valid, bus_ir_data_ready = 0;
  logic [W-1:0] bus_ir_addr_bits = '0, bus_ir_data_bits;
  logic bus_dr_addr_valid = 0, bus_dr_addr_ready, bus_dr_data_valid, bus_dr_data_ready = 0;
  logic [W-1:0] bus_dr_addr_bits = '0, bus_dr_data_bits;
  logic bus_dw_req_valid = 0, bus_dw_req_ready, bus_dw_resp_valid, bus_dw_resp_ready = 0;
  logic [W-1:0] bus_dw_req_bits_addr = '0, bus_dw_req_bits_data = '0;
  logic [SW-1:0] bus_dw_req_bits_strobe = '0;
  logic [0:0] bus_dw_resp_bits;
  logic mem_req_valid, mem_req_ready = 0, mem_req_write;
  logic [W-1:0] mem_req_addr, mem_req_data;
  logic [SW-1:0] mem_req_strobe;
  logic mem_resp_valid = 0, mem_resp_ready, mem_resp_err = 0;
  logic [W-1:0] mem_resp_data = '0;

  bus_arbiter dut (
    .clock(clock), .reset(reset),
    .bus_ir_addr_valid(bus_ir_addr_valid), .bus_ir_addr_ready(bus_ir_addr_ready), .bus_ir_addr_bits(bus_ir_addr_bits),
    .bus_ir_data_valid(bus_ir_data_valid), .bus_ir_data_ready(bus_ir_data_ready), .bus_ir_data_bits(bus_ir_data_bits),
    .bus_dr_addr_valid(bus_dr_addr_valid), .bus_dr_addr_ready(bus_dr_addr_ready), .bus_dr_addr_bits(bus_dr_addr_bits),
    .bus_dr_data_valid(bus_dr_data_valid), .bus_dr_data_ready(bus_dr_data_ready), .bus_dr_data_bits(bus_dr_data_bits),
    .bus_dw_req_valid(bus_dw_req_valid), .bus_dw_req_ready(bus_dw_req_ready),
    .bus_dw_req_bits_addr(bus_dw_req_bits_addr), .bus_dw_req_bits_data(bus_dw_req_bits_data),
    .bus_dw_req_bits_strobe(bus_dw_req_bits_strobe),
    .bus_dw_resp_valid(bus_dw_resp_valid), .bus_dw_resp_ready(bus_dw_resp_ready), .bus_dw_resp_bits(bus_dw_resp_bits),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_strobe(mem_req_strobe),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int last_id = 2;
  logic [W-1:0] mem_m [logic [W-1:0]];
  logic [W-1:0] ra [3];
  logic [W-1:0] wd;
  logic [SW-1:0] ws;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mem_rd(input logic [W-1:0] a);
    return mem_m.exists(a) ? mem_m[a] : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic int pick(input logic [2:0] v);
    for (int k = 1; k <= 3; k++)
      if (v[(last_id + k) % 3]) return (last_id + k) % 3;
    return -1;
  endfunction

  task automatic drive(input logic [2:0] v);
    bus_ir_addr_valid = v[0];
    bus_dr_addr_valid = v[1];
    bus_dw_req_valid = v[2];
    bus_ir_addr_bits = ra[0];
    bus_dr_addr_bits = ra[1];
    bus_dw_req_bits_addr = ra[2];
    bus_dw_req_bits_data = wd;
    bus_dw_req_bits_strobe = ws;
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < 3; i++) ra[i] = $urandom;
    wd = $urandom;
    ws = SW'($urandom);
  endtask

  task automatic round(input logic [2:0] v, input int mwait, input int rwait, input int dwait, input logic err);
    int w;
    logic [W-1:0] e_addr, e_data, rdata, cur;
    logic [SW-1:0] e_strb;
    logic e_wr;
    @(negedge clock);
    drive(v);
    w = pick(v);
    #1;
    chk("grant", {29'b0, bus_dw_req_ready, bus_dr_addr_ready, bus_ir_addr_ready}, (w < 0) ? 0 : (1 << w));
    if (w < 0) return;
    last_id = w;
    e_wr = (w == 2);
    e_addr = ra[w];
    e_data = e_wr ? wd : '0;
    e_strb = e_wr ? ws : '0;
    @(negedge clock);
    drive(3'b000);
    chk("req_valid", W'(mem_req_valid), 1);
    chk("req_write", W'(mem_req_write), W'(e_wr));
    chk("req_addr", mem_req_addr, e_addr);
    chk("req_data", mem_req_data, e_data);
    chk("req_strobe", W'(mem_req_strobe), W'(e_strb));
    mem_resp_valid = (mwait > 0);
    mem_resp_data = $urandom;
    repeat (mwait) begin
      @(negedge clock);
      chk("req_hold_valid", W'(mem_req_valid), 1);
      chk("req_hold_addr", mem_req_addr, e_addr);
      chk("req_hold_data", mem_req_data, e_data);
      chk("resp_ready_in_req", W'(mem_resp_ready), 0);
    end
    mem_resp_valid = 0;
    mem_req_ready = 1;
    @(negedge clock);
    mem_req_ready = 0;
    chk("req_drop", W'(mem_req_valid), 0);
    chk("resp_ready", W'(mem_resp_ready), 1);
    repeat (rwait) begin
      @(negedge clock);
      chk("resp_wait_ready", W'(mem_resp_ready), 1);
      chk("resp_wait_valids", {29'b0, bus_dw_resp_valid, bus_dr_data_valid, bus_ir_data_valid}, 0);
    end
    rdata = e_wr ? W'($urandom) : mem_rd(e_addr);
    if (e_wr && !err) begin
      cur = mem_rd(e_addr);
      for (int b = 0; b < SW; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
      mem_m[e_addr] = cur;
    end
    mem_resp_data = rdata;
    mem_resp_err = err;
    mem_resp_valid = 1;
    @(negedge clock);
    mem_resp_valid = 0;
    mem_resp_data = $urandom;
    mem_resp_err = ~err;
    bus_ir_data_ready = (w != 0);
    bus_dr_data_ready = (w != 1);
    bus_dw_resp_ready = (w != 2);
    for (int d = 0; d <= dwait; d++) begin
      if (d > 0) @(negedge clock);
      chk("deliver_valids", {29'b0, bus_dw_resp_valid, bus_dr_data_valid, bus_ir_data_valid}, 1 << w);
      chk("deliver_resp_ready", W'(mem_resp_ready), 0);
      if (w == 0) chk("ir_data", bus_ir_data_bits, rdata);
      if (w == 1) chk("dr_data", bus_dr_data_bits, rdata);
      if (w == 2) chk("dw_resp", W'(bus_dw_resp_bits), W'(err));
    end
    bus_ir_data_ready = 1;
    bus_dr_data_ready = 1;
    bus_dw_resp_ready = 1;
    @(negedge clock);
    bus_ir_data_ready = 0;
    bus_dr_data_ready = 0;
    bus_dw_resp_ready = 0;
    mem_resp_err = 0;
    chk("idle_valids", {28'b0, mem_req_valid, bus_dw_resp_valid, bus_dr_data_valid, bus_ir_data_valid}, 0);
  endtask

  initial begin
    int w;
    randomize_reqs();
    drive(3'b111);
    repeat (3) @(negedge clock);
    #1;
    chk("rst_readies", {29'b0, bus_dw_req_ready, bus_dr_addr_ready, bus_ir_addr_ready}, 0);
    chk("rst_valids", {28'b0, mem_req_valid, bus_dw_resp_valid, bus_dr_data_valid, bus_ir_data_valid}, 0);
    chk("rst_resp_ready", W'(mem_resp_ready), 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_write", W'(mem_req_write), 0);
    chk("rst_ir_bits", bus_ir_data_bits, 0);
    reset = 1;
    drive(3'b000);
    // single IR read
    ra[0] = 32'h10;
    mem_m[32'h10] = 32'h0050_0093;
    round(3'b001, 0, 0, 0, 0);
    // single write
    ra[2] = 32'h100; wd = 32'hDEAD_BEEF; ws = 4'hF;
    round(3'b100, 0, 0, 0, 0);
    // contention: IR, DR, DW, then IR again
    for (int i = 0; i < 4; i++) begin
      randomize_reqs();
      round(3'b111, 0, 0, 0, 0);
    end
    // backpressure on both sides
    randomize_reqs();
    round(3'b010, 5, 0, 3, 0);
    // write error
    randomize_reqs();
    round(3'b100, 0, 1, 0, 1);
    // withdrawn request keeps the pointer
    randomize_reqs();
    @(negedge clock);
    drive(3'b011);
    #1;
    w = pick(3'b011);
    chk("withdraw_grant", {29'b0, bus_dw_req_ready, bus_dr_addr_ready, bus_ir_addr_ready}, 1 << w);
    #2;
    drive(3'b000);
    @(negedge clock);
    chk("withdraw_no_req", W'(mem_req_valid), 0);
    round(3'b111, 0, 0, 0, 0);
    // reset while waiting in RESP
    randomize_reqs();
    @(negedge clock);
    drive(3'b110);
    w = pick(3'b110);
    #1;
    chk("rr_grant", {29'b0, bus_dw_req_ready, bus_dr_addr_ready, bus_ir_addr_ready}, 1 << w);
    @(negedge clock);
    drive(3'b000);
    mem_req_ready = 1;
    @(negedge clock);
    mem_req_ready = 0;
    chk("rr_in_resp", W'(mem_resp_ready), 1);
    reset = 0;
    drive(3'b111);
    #1;
    chk("rr_readies_low", {29'b0, bus_dw_req_ready, bus_dr_addr_ready, bus_ir_addr_ready}, 0);
    @(negedge clock);
    reset = 1;
    drive(3'b000);
    mem_resp_valid = 1;
    chk("rr_valids", {28'b0, mem_req_valid, bus_dw_resp_valid, bus_dr_data_valid, bus_ir_data_valid}, 0);
    chk("rr_resp_ready", W'(mem_resp_ready), 0);
    chk("rr_state", W'(dut.state), W'(IDLE));
    chk("rr_req_addr", mem_req_addr, 0);
    @(negedge clock);
    mem_resp_valid = 0;
    chk("rr_ignore_resp", {29'b0, bus_dw_resp_valid, bus_dr_data_valid, bus_ir_data_valid}, 0);
    last_id = 2;
    randomize_reqs();
    round(3'b111, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      randomize_reqs();
      round(3'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom_range(0, 2),
            $urandom_range(0, 2), 1'($urandom));
    end
    // read back a written location through DR
    ra[1] = 32'h100;
    round(3'b010, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
